// File: rtl/led_event_scheduler_pkg.sv
// Shared types for the LED event scheduler: animation kinds, FSM states and
// the simultaneous-event priority selector.
package led_anim_pkg;

    typedef enum logic [1:0] {
        GOAL_P1 = 2'b00,
        GOAL_P2 = 2'b01,
        WIN_P1  = 2'b10,
        WIN_P2  = 2'b11
    } anim_kind_t;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } sched_state_t;

    typedef struct packed {
        logic       valid;
        anim_kind_t kind;
    } event_sel_t;

    // Wins outrank goals; player 1 outranks player 2 within each class.
    function automatic event_sel_t select_event(
        input logic win_p1,
        input logic win_p2,
        input logic goal_p1,
        input logic goal_p2
    );
        event_sel_t sel;
        sel.valid = win_p1 | win_p2 | goal_p1 | goal_p2;
        if (win_p1)       sel.kind = WIN_P1;
        else if (win_p2)  sel.kind = WIN_P2;
        else if (goal_p1) sel.kind = GOAL_P1;
        else              sel.kind = GOAL_P2;
        return sel;
    endfunction

    function automatic logic is_win(input anim_kind_t kind);
        return kind[1];
    endfunction

endpackage

// File: rtl/led_event_scheduler_if.sv
// Start/done handshake between the event scheduler (master) and the LED
// animation player (slave).
interface led_event_scheduler_if;
    import led_anim_pkg::*;

    logic       anim_start;
    anim_kind_t anim_kind;
    logic       anim_abort;
    logic       anim_done;

    modport master (
        output anim_start,
        output anim_kind,
        output anim_abort,
        input  anim_done
    );

    modport slave (
        input  anim_start,
        input  anim_kind,
        input  anim_abort,
        output anim_done
    );

endinterface

// File: rtl/led_event_scheduler_event_fifo.sv
// Synchronous DEPTH x 2-bit FIFO of pending animation kinds. Flush empties the
// queue; a push in the same cycle lands as the sole entry.
module event_fifo
    import led_anim_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  anim_kind_t                   din,
    output anim_kind_t                   dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    anim_kind_t    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop || flush);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[flush ? '0 : wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= do_push ? AW'(1) : '0;
            count  <= do_push ? CW'(1) : '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/led_event_scheduler.sv
// Queues goal/win events and plays them one at a time on the shared LED
// animation player. Optional macro WIN_PREEMPT_EN lets a win abort a goal.
module led_event_scheduler
    import led_anim_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                         CLOCK,
    input  logic                         RESET,
    input  logic                         goal_player_1,
    input  logic                         goal_player_2,
    input  logic                         win_player_1,
    input  logic                         win_player_2,
    input  logic                         new_game,
    input  logic                         clear_flags,
    led_event_scheduler_if.master        anim,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   queue_count,
    output logic                         game_over,
    output logic                         overflow,
    output logic                         timeout_err
);

    localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);

    sched_state_t   state;
    sched_state_t   state_nx;
    logic [WDW-1:0] wd_cnt;
    logic [WDW-1:0] wd_cnt_nx;
    logic           start_q;
    logic           start_nx;
    anim_kind_t     kind_q;
    anim_kind_t     kind_nx;
    logic           timed_out;
    logic           game_over_nx;
    logic           overflow_nx;
    logic           timeout_nx;

    event_sel_t     sel;
    logic           lockout;
    logic           preempt;
    logic           drop;
    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_flush;
    logic           fifo_full;
    logic           fifo_empty;
    anim_kind_t     head;

    // new_game clears the lockout before this edge's events are evaluated.
    assign lockout = game_over && !new_game;
    assign sel     = select_event(win_player_1, win_player_2, goal_player_1, goal_player_2);

`ifdef WIN_PREEMPT_EN
    assign preempt = sel.valid && !lockout && is_win(sel.kind) && (state == PLAY) && !is_win(kind_q);
`else
    assign preempt = 1'b0;
`endif

    assign fifo_flush = new_game || preempt;
    assign fifo_pop   = (state == IDLE) && !fifo_empty && !new_game;
    assign drop       = sel.valid && !lockout && fifo_full && !fifo_pop && !fifo_flush;
    assign fifo_push  = sel.valid && !lockout && !drop;

    event_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLOCK),
        .rst   (RESET),
        .flush (fifo_flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (sel.kind),
        .dout  (head),
        .count (queue_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_nx  = state;
        wd_cnt_nx = wd_cnt;
        start_nx  = 1'b0;
        kind_nx   = kind_q;
        timed_out = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_pop) begin
                    state_nx  = PLAY;
                    start_nx  = 1'b1;
                    kind_nx   = head;
                    wd_cnt_nx = '0;
                end
            end
            PLAY: begin
                if (preempt || anim.anim_done) begin
                    state_nx = IDLE;
                end else if (wd_cnt >= WDW'(TIMEOUT_CYCLES - 1)) begin
                    state_nx  = IDLE;
                    timed_out = 1'b1;
                end else begin
                    wd_cnt_nx = wd_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        // Sticky flags: a new set in the same cycle beats clear_flags.
        game_over_nx = lockout || (fifo_push && is_win(sel.kind));
        overflow_nx  = (overflow && !clear_flags) || drop;
        timeout_nx   = (timeout_err && !clear_flags) || timed_out;
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            wd_cnt      <= '0;
            start_q     <= 1'b0;
            kind_q      <= GOAL_P1;
            game_over   <= 1'b0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nx;
            wd_cnt      <= wd_cnt_nx;
            start_q     <= start_nx;
            kind_q      <= kind_nx;
            game_over   <= game_over_nx;
            overflow    <= overflow_nx;
            timeout_err <= timeout_nx;
        end
    end

`ifdef WIN_PREEMPT_EN
    logic abort_q;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) abort_q <= 1'b0;
        else       abort_q <= preempt;
    end

    assign anim.anim_abort = abort_q;
`else
    assign anim.anim_abort = 1'b0;
`endif

    assign anim.anim_start = start_q;
    assign anim.anim_kind  = kind_q;
    assign busy            = (state == PLAY);

endmodule

// File: tb/tb_led_event_scheduler.sv
// Self-checking bench for led_event_scheduler: directed scenarios plus a
// randomized run checked against a queue-based behavioural model.
module tb_led_event_scheduler;

    localparam int DEPTH = 4;
    localparam int TMO   = 1023;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b0;
    logic       g1 = 1'b0, g2 = 1'b0, w1 = 1'b0, w2 = 1'b0;
    logic       ng = 1'b0, cf = 1'b0;
    logic       busy, go, ovf, tmo;
    logic [2:0] qc;
    int         checks = 0;
    int         failures = 0;

    led_event_scheduler_if anim();

    always #5 CLOCK = ~CLOCK;

    led_event_scheduler #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .goal_player_1 (g1),
        .goal_player_2 (g2),
        .win_player_1  (w1),
        .win_player_2  (w2),
        .new_game      (ng),
        .clear_flags   (cf),
        .anim          (anim),
        .busy          (busy),
        .queue_count   (qc),
        .game_over     (go),
        .overflow      (ovf),
        .timeout_err   (tmo)
    );

    // Behavioural model: pending kinds as a queue, play time counted in cycles.
    int mq[$];
    bit m_play, m_start, m_abort, m_go, m_ovf, m_tmo;
    int m_kind, m_played;
    int e_ev;
    bit e_go, e_pop, e_pre, e_pushed;

    always @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            mq.delete();
            m_play = 0; m_start = 0; m_abort = 0; m_go = 0; m_ovf = 0; m_tmo = 0;
            m_kind = 0; m_played = 0;
        end else begin
            e_go = ng ? 1'b0 : m_go;
            e_ev = -1;
            if (!e_go) begin
                if (w1)      e_ev = 2;
                else if (w2) e_ev = 3;
                else if (g1) e_ev = 0;
                else if (g2) e_ev = 1;
            end
            e_pre = 0;
`ifdef WIN_PREEMPT_EN
            e_pre = (e_ev >= 2) && m_play && (m_kind < 2);
`endif
            e_pop   = !m_play && (mq.size() > 0) && !ng;
            m_start = 0;
            m_abort = 0;
            if (cf) begin m_ovf = 0; m_tmo = 0; end
            if (e_pop) begin
                m_kind   = mq.pop_front();
                m_start  = 1;
                m_play   = 1;
                m_played = 1;
            end else if (m_play) begin
                if (e_pre) begin
                    m_play = 0; m_abort = 1;
                end else if (anim.anim_done) begin
                    m_play = 0;
                end else if (m_played >= TMO) begin
                    m_play = 0; m_tmo = 1;
                end else begin
                    m_played = m_played + 1;
                end
            end
            if (ng || e_pre) mq.delete();
            e_pushed = 0;
            if (e_ev >= 0) begin
                if (mq.size() < DEPTH) begin mq.push_back(e_ev); e_pushed = 1; end
                else m_ovf = 1;
            end
            m_go = e_go || (e_pushed && e_ev >= 2);
        end
    end

    function automatic logic [10:0] dut_vec();
        return {anim.anim_start, anim.anim_kind, anim.anim_abort, busy, qc, go, ovf, tmo};
    endfunction

    function automatic logic [10:0] mdl_vec();
        return {m_start, 2'(m_kind), m_abort, m_play, 3'(mq.size()), m_go, m_ovf, m_tmo};
    endfunction

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        step();
        step();
        checks++;
        if (dut_vec() !== 11'd0) begin
            failures++; $display("FAIL reset_outputs got=%b exp=%b", dut_vec(), 11'd0);
        end
        RESET = 1'b0;
        step();
        checks++;
        if (dut_vec() !== mdl_vec()) begin
            failures++; $display("FAIL reset_model got=%b exp=%b", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_single_goal();
        g2 = 1'b1; step(); g2 = 1'b0;
        checks++;
        if (qc !== 3'd1 || anim.anim_start !== 1'b0) begin
            failures++; $display("FAIL g2_enqueue got qc=%0d start=%b exp qc=1 start=0", qc, anim.anim_start);
        end
        step();
        checks++;
        if (anim.anim_start !== 1'b1 || anim.anim_kind !== 2'b01 || busy !== 1'b1) begin
            failures++; $display("FAIL g2_start got start=%b kind=%b busy=%b exp 1 01 1", anim.anim_start, anim.anim_kind, busy);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (busy !== 1'b1 || anim.anim_start !== 1'b0 || anim.anim_kind !== 2'b01) begin
                failures++; $display("FAIL g2_hold got busy=%b start=%b kind=%b exp 1 0 01", busy, anim.anim_start, anim.anim_kind);
            end
        end
        anim.anim_done = 1'b1; step(); anim.anim_done = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL g2_done got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_priority_lockout();
        g1 = 1'b1; w2 = 1'b1; step(); g1 = 1'b0; w2 = 1'b0;
        checks++;
        if (qc !== 3'd1 || go !== 1'b1) begin
            failures++; $display("FAIL prio_enqueue got qc=%0d go=%b exp qc=1 go=1", qc, go);
        end
        step();
        checks++;
        if (anim.anim_start !== 1'b1 || anim.anim_kind !== 2'b11 || qc !== 3'd0) begin
            failures++; $display("FAIL prio_kind got start=%b kind=%b qc=%0d exp 1 11 0", anim.anim_start, anim.anim_kind, qc);
        end
        g1 = 1'b1; step(); g1 = 1'b0;
        checks++;
        if (qc !== 3'd0) begin
            failures++; $display("FAIL lockout_qc got=%0d exp=0", qc);
        end
        anim.anim_done = 1'b1; step(); anim.anim_done = 1'b0;
        ng = 1'b1; g2 = 1'b1; step(); ng = 1'b0; g2 = 1'b0;
        checks++;
        if (go !== 1'b0 || qc !== 3'd1) begin
            failures++; $display("FAIL newgame_event got go=%b qc=%0d exp go=0 qc=1", go, qc);
        end
        step();
        checks++;
        if (anim.anim_start !== 1'b1 || anim.anim_kind !== 2'b01) begin
            failures++; $display("FAIL newgame_start got start=%b kind=%b exp 1 01", anim.anim_start, anim.anim_kind);
        end
        anim.anim_done = 1'b1; step(); anim.anim_done = 1'b0;
    endtask

    task automatic test_overflow();
        int first;
        first = -1;
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 1) == 0) g1 = 1'b1; else g2 = 1'b1;
            if (first < 0) first = g1 ? 0 : 1;
            step();
            g1 = 1'b0; g2 = 1'b0;
        end
        checks++;
        if (qc !== 3'd4 || ovf !== 1'b1) begin
            failures++; $display("FAIL ovf_set got qc=%0d ovf=%b exp qc=4 ovf=1", qc, ovf);
        end
        checks++;
        if (busy !== 1'b1 || anim.anim_kind !== 2'(first)) begin
            failures++; $display("FAIL ovf_first_kind got busy=%b kind=%b exp 1 %0d", busy, anim.anim_kind, first);
        end
        cf = 1'b1; step(); cf = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            failures++; $display("FAIL ovf_clear got=%b exp=0", ovf);
        end
    endtask

    task automatic test_timeout();
        int k;
        anim.anim_done = 1'b1; step(); anim.anim_done = 1'b0;
        checks++;
        if (anim.anim_start !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL no_back_to_back got start=%b busy=%b exp 0 0", anim.anim_start, busy);
        end
        step();
        checks++;
        if (anim.anim_start !== 1'b1 || qc !== 3'd3) begin
            failures++; $display("FAIL timeout_setup got start=%b qc=%0d exp 1 3", anim.anim_start, qc);
        end
        k = 0;
        while (busy === 1'b1 && k < 2000) begin
            step();
            k++;
        end
        checks++;
        if (k !== TMO) begin
            failures++; $display("FAIL timeout_len got=%0d exp=%0d", k, TMO);
        end
        checks++;
        if (tmo !== 1'b1 || anim.anim_start !== 1'b0) begin
            failures++; $display("FAIL timeout_flag got tmo=%b start=%b exp 1 0", tmo, anim.anim_start);
        end
        step();
        checks++;
        if (anim.anim_start !== 1'b1 || qc !== 3'd2) begin
            failures++; $display("FAIL timeout_next_start got start=%b qc=%0d exp 1 2", anim.anim_start, qc);
        end
    endtask

    task automatic test_reset_mid_play();
        g1 = 1'b1; step(); g1 = 1'b0;
        checks++;
        if (qc !== 3'd3 || busy !== 1'b1) begin
            failures++; $display("FAIL rst_pre got qc=%0d busy=%b exp 3 1", qc, busy);
        end
        #3 RESET = 1'b1;
        #1;
        checks++;
        if (dut_vec() !== 11'd0) begin
            failures++; $display("FAIL rst_async got=%b exp=%b", dut_vec(), 11'd0);
        end
        #2 RESET = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if (anim.anim_start !== 1'b0 || qc !== 3'd0 || busy !== 1'b0) begin
                failures++; $display("FAIL rst_no_start got start=%b qc=%0d busy=%b exp 0 0 0", anim.anim_start, qc, busy);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            w1 = ($urandom_range(0, 15) == 0);
            w2 = ($urandom_range(0, 15) == 0);
            g1 = ($urandom_range(0, 3) == 0);
            g2 = ($urandom_range(0, 3) == 0);
            ng = ($urandom_range(0, 29) == 0);
            cf = ($urandom_range(0, 19) == 0);
            anim.anim_done = ($urandom_range(0, 5) == 0);
            step();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                failures++;
                if (failures < 20)
                    $display("FAIL random_cycle %0d got=%b exp=%b", i, dut_vec(), mdl_vec());
            end
        end
        {w1, w2, g1, g2, ng, cf} = '0;
        anim.anim_done = 1'b0;
    endtask

`ifdef WIN_PREEMPT_EN
    task automatic test_preempt();
        RESET = 1'b1; step(); RESET = 1'b0; step();
        g1 = 1'b1; step(); g1 = 1'b0;
        step();
        g2 = 1'b1; step(); g2 = 1'b0;
        g1 = 1'b1; step(); g1 = 1'b0;
        checks++;
        if (qc !== 3'd2 || busy !== 1'b1 || anim.anim_kind !== 2'b00) begin
            failures++; $display("FAIL preempt_setup got qc=%0d busy=%b kind=%b exp 2 1 00", qc, busy, anim.anim_kind);
        end
        w1 = 1'b1; step(); w1 = 1'b0;
        checks++;
        if (anim.anim_abort !== 1'b1 || qc !== 3'd1 || busy !== 1'b0) begin
            failures++; $display("FAIL preempt_abort got abort=%b qc=%0d busy=%b exp 1 1 0", anim.anim_abort, qc, busy);
        end
        step();
        checks++;
        if (anim.anim_abort !== 1'b0 || anim.anim_start !== 1'b1 || anim.anim_kind !== 2'b10) begin
            failures++; $display("FAIL preempt_start got abort=%b start=%b kind=%b exp 0 1 10", anim.anim_abort, anim.anim_start, anim.anim_kind);
        end
    endtask
`endif

    initial begin
        anim.anim_done = 1'b0;
        test_reset();
        test_single_goal();
        test_priority_lockout();
        test_overflow();
        test_timeout();
        test_reset_mid_play();
        test_random();
`ifdef WIN_PREEMPT_EN
        test_preempt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_event_scheduler.md
Name: led_event_scheduler

Overview:
- Sits between the game logic (goal/win pulses) and the LED animation player, which is one shared resource.
- Captures score events and queues them.
- Starts one animation at a time through a start/done handshake.
- Locks out further events after a win until a new game begins.

Parameters:
- DEPTH, 4, event queue entries; power of two, at least 2.
- TIMEOUT_CYCLES, 1023, cycles in PLAY without anim_done before the scheduler gives up.

Ports:
- CLOCK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- goal_player_1  in  1  one-cycle pulse
- goal_player_2  in  1  one-cycle pulse
- win_player_1  in  1  one-cycle pulse
- win_player_2  in  1  one-cycle pulse
- new_game  in  1  synchronous pulse: flush queue, clear game_over
- clear_flags  in  1  clears the overflow and timeout_err sticky flags
- anim_done  in  1  pulse from the player: animation finished
- anim_start  out  1  one-cycle pulse: begin animation anim_kind
- anim_kind  out  2  00 goal1, 01 goal2, 10 win1, 11 win2; held stable from anim_start until the next start
- anim_abort  out  1  one-cycle pulse: stop the current animation (only with WIN_PREEMPT_EN, else tied 0)
- busy  out  1  high in PLAY
- queue_count  out  $clog2(DEPTH+1)  occupied entries
- game_over  out  1  a win has been accepted
- overflow  out  1  sticky: an event was dropped because the queue was full
- timeout_err  out  1  sticky: the player never returned anim_done

Behaviour:
- Reset values: state IDLE; all outputs 0; queue empty.
- Capture: all event inputs are sampled each edge.
  - Simultaneous events resolve to one by priority: win_player_1 > win_player_2 > goal_player_1 > goal_player_2.
  - The losing events are discarded silently.
- Lockout: while game_over=1, every event input is ignored.
  - An accepted win sets game_over at the same edge it is enqueued.
- Enqueue: a selected event is written at the sampling edge, so queue_count rises the following cycle.
  - Queue full with no pop that edge: the event is dropped and overflow is set.
  - Full with a pop that same edge: the event is accepted and count is unchanged.
- FSM states: IDLE, PLAY.
  - IDLE with count>0: at the edge, pop the head, register it into anim_kind, assert anim_start for exactly one cycle, go to PLAY.
  - No bypass path. Latency: an event presented in cycle n gives anim_start high in cycle n+2 when IDLE and empty.
  - PLAY: anim_done=1 returns to IDLE. The next start comes at the earliest one cycle after returning to IDLE, never back-to-back with done.
  - PLAY watchdog: after TIMEOUT_CYCLES cycles with no anim_done, set timeout_err and go to IDLE. The counter clears on entry to PLAY.
  - anim_done in IDLE is ignored. anim_done in the cycle anim_start is high is accepted.
- new_game:
  - Empties the queue and clears game_over at the edge.
  - Does not disturb a PLAY in progress.
  - An event in the same cycle is evaluated after the clear: accepted and enqueued into the emptied queue.
- clear_flags together with a new overflow or timeout in the same cycle: the set wins.
- RESET mid-PLAY: immediate return to reset values, with no anim_abort pulse.
- Counts are unsigned and never wrap: queue_count stays in 0..DEPTH, and the watchdog counter saturates.

Optional Feature:
- Macro: WIN_PREEMPT_EN.
- Enabled: an accepted win while in PLAY with a goal kind (00/01) does the following at that edge:
  - pulses anim_abort for one cycle;
  - flushes all queued goals;
  - writes the win as the sole queue entry;
  - moves the FSM to IDLE, so the win starts two cycles after the event.
  - A win arriving while a win is playing cannot occur because of the lockout.
- Disabled: anim_abort is tied to 0, and a win waits behind the goals already queued.

Decomposition:
- Package led_anim_pkg holds:
  - anim_kind codes (GOAL_P1=2'b00, GOAL_P2=2'b01, WIN_P1=2'b10, WIN_P2=2'b11);
  - FSM state encoding (IDLE, PLAY);
  - the priority-select function.
- One natural sub-module: event_fifo, a synchronous FIFO of DEPTH x 2 bits with push, pop, flush, count, full and empty.

Test Plan:
- Single goal_player_2 pulse at cycle 10, queue empty -> anim_start=1 and anim_kind=01 in cycle 12; busy stays high until anim_done, then returns low.
- goal_player_1 and win_player_2 in the same cycle -> one entry with kind 11; game_over=1; a later goal_player_1 pulse leaves queue_count unchanged.
- Six goal pulses on consecutive cycles while the player holds anim_done low, DEPTH=4 -> first pops at start, queue_count reaches 4, the excess event is dropped and overflow=1; clear_flags drops overflow to 0.
- No anim_done for 1023 cycles after anim_start -> timeout_err=1 and FSM back in IDLE; the next queued event starts one cycle later.
- RESET asserted mid-PLAY with 3 queued events -> all outputs 0 asynchronously; after release, no anim_start until a new event arrives.
- WIN_PREEMPT_EN: goal kind 00 playing with two goals queued, then win_player_1 -> anim_abort pulse; queue_count=1; anim_start with kind 10 two cycles after the win.
